bcd_addsub_serial: RTL and testbench
====================================

// Module: bcd_addsub_serial
// PURPOSE
//   Parametrised, digit-serial BCD adder/subtractor for the decimal datapath.
//   It replaces the fixed 14-digit combinational BCD add and processes DPC digits per cycle, LSD first.
//   Supports A+B, and A-B by 10's complement. A negative difference is returned as sign plus magnitude.
//   Uses a valid/ready handshake on both input and output, so it slots between the
//   multiplier's partial-product stages.
// PARAMETERS
//   NDIGITS  14  number of BCD digits per operand/result; must be a multiple of DPC
//   DPC      2   digits processed per clock; NSL = NDIGITS/DPC slices
// PORTS
//   clk        in   1            rising-edge clock
//   rst        in   1            asynchronous, active-high reset
//   in_valid   in   1            operands/op valid
//   in_ready   out  1            block can accept (high only in IDLE)
//   op         in   1            0 = A+B, 1 = A-B
//   a          in   4*NDIGITS    operand A, packed BCD, digit 0 at [3:0]
//   b          in   4*NDIGITS    operand B, packed BCD
//   out_valid  out  1            result valid, held until taken
//   out_ready  in   1            consumer accepts result
//   result     out  4*NDIGITS    BCD result (magnitude for op=1)
//   carry_out  out  1            decimal carry out of MSD (op=0); 0 for op=1
//   neg        out  1            op=1 and A<B; result holds |A-B|
//   err        out  1            an accepted operand contained a digit >9
// BEHAVIOUR
//   Reset (async, any state): state=IDLE. result=0, carry_out=0, neg=0, err=0, out_valid=0.
//     Slice counter=0 and carry=0. in_ready=1 once in IDLE.
//   FSM: IDLE -> RUN -> (COMP) -> DONE -> IDLE.
//   IDLE: in_ready=1. On in_valid&in_ready, the block latches a, b and op.
//     It also computes err over all latched digits, sets carry=op, slice=0, then goes to RUN.
//   RUN: each cycle, digit slice `slice` (DPC digits) is processed.
//     Per digit: s = a_d + b'_d + carry, where b'_d = b_d (op=0) or 9-b_d (op=1).
//     If s>9: digit=s+6 (mod 16), carry=1. Otherwise digit=s, carry=0.
//     Carry ripples across the DPC digits within the cycle, then registers to the next slice.
//   Last slice (slice=NSL-1), by case:
//     op=0: carry_out=final carry, then go to DONE.
//     op=1, final carry=1: A>=B, neg=0, then go to DONE.
//     op=1, final carry=0: A<B, neg=1, then go to COMP.
//   COMP: the same slice datapath re-complements the result register.
//     It runs NSL cycles with digit=9-r_d, +1 injected at slice 0, and the final carry is discarded.
//   DONE: out_valid=1; result/carry_out/neg/err are stable.
//     On out_ready, out_valid drops next edge and the block returns to IDLE.
//   Latency (accepting edge -> out_valid high): NSL cycles for op=0 or non-negative op=1.
//     2*NSL cycles for negative op=1.
//   Throughput: the next accept is earliest 1 cycle after the result is taken; no overlap.
//   err=1: result forced to 0, carry_out=0, neg=0. Timing is unchanged (full NSL cycles).
//   in_valid outside IDLE is ignored. Inputs are sampled only at the accept edge.
//     Later changes on a/b/op have no effect.
//   out_ready while out_valid=0 is ignored.
//   Reset mid-RUN/COMP/DONE: the operation is aborted and no out_valid pulse appears.
//   Wrap: A+B overflow yields result mod 10^NDIGITS and carry_out=1.
// TESTING
//   NDIGITS=14, DPC=2 (NSL=7) unless noted.
//   1. op=0, A=99999999999999, B=00000000000001 -> result=0, carry_out=1, out_valid at +7.
//   2. op=1, A=5, B=7 -> result=00000000000002, neg=1, carry_out=0, out_valid at +14.
//   3. op=1, A=B=12345678901234 -> result=0, neg=0, out_valid at +7.
//   4. Backpressure: op=0, 47+58. Hold out_ready=0 for 5 cycles and pulse in_valid.
//      -> result=105 stable, in_ready=0, the second request is not taken.
//      -> After out_ready, IDLE; in_ready=1 on the next cycle.
//   5. Reset at cycle 3 of RUN -> outputs return to reset values immediately.
//      -> No out_valid; the following 1+1 gives 2 with correct latency.
//   6. A digit 0xA in a -> err=1, result=0; repeat test 1 with DPC=1 and DPC=14.
//      -> Latency 14 and 1 respectively, same results.

Source files
------------

// File: rtl/bcd_addsub_serial_if.sv
// Valid/ready handshake and data bundle for the digit-serial BCD adder/subtractor.
// The producer and consumer use master; the arithmetic block uses slave.
interface bcd_addsub_serial_if #(
  parameter int NDIGITS = 14
);
  logic                   in_valid;
  logic                   in_ready;
  logic                   op;
  logic [4*NDIGITS-1:0]   a;
  logic [4*NDIGITS-1:0]   b;
  logic                   out_valid;
  logic                   out_ready;
  logic [4*NDIGITS-1:0]   result;
  logic                   carry_out;
  logic                   neg;
  logic                   err;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, carry_out, neg, err
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, carry_out, neg, err
  );
endinterface

// File: rtl/bcd_addsub_serial.sv
// Digit-serial BCD adder/subtractor: DPC digits per clock, least significant slice first.
// A-B is formed as A + 9's(B) + 1; a missing final carry means A<B, and the result is
// then re-complemented in a second pass through the same slice adder to give |A-B|.
// The interface instance must be built with the same NDIGITS as this module.
module bcd_addsub_serial #(
  parameter int NDIGITS = 14,
  parameter int DPC     = 2   // NDIGITS must be a multiple of DPC
) (
  input  logic               clk,
  input  logic               rst,
  bcd_addsub_serial_if.slave bus
);
  localparam int NSL = NDIGITS / DPC;
  localparam int SLW = 4 * DPC;
  localparam int W   = 4 * NDIGITS;
  localparam int CW  = (NSL > 1) ? $clog2(NSL) : 1;
  localparam logic [CW-1:0] LAST_SLICE = CW'(NSL - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    COMP = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic            op_q;
  logic [W-1:0]    res_q;
  logic            carry_q;
  logic            carry_out_q;
  logic            neg_q;
  logic            err_q;
  logic [CW-1:0]   slice_q;
  logic            accept;
  logic            last;
  logic [SLW-1:0]  sum_slice;
  logic            sum_carry;
  logic [3:0]      xd;
  logic [3:0]      yd;
  logic [4:0]      s;
  logic            c;

  // True when any packed digit of the operand is not a legal BCD value.
  function automatic logic has_bad_digit(input logic [W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int d = 0; d < NDIGITS; d++) begin
      if (v[4*d +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  assign last          = (slice_q == LAST_SLICE);
  assign bus.result    = res_q;
  assign bus.carry_out = carry_out_q;
  assign bus.neg       = neg_q;
  assign bus.err       = err_q;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: every clocked assignment is non-blocking so all registers update from pre-edge values.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Capture operands and operation at the accepting edge only.
  always_ff @(posedge clk) begin
    // NOTE: operand registers carry no reset; they are only read after an accept has loaded them.
    if (accept) begin
      a_q  <= bus.a;
      b_q  <= bus.b;
      op_q <= bus.op;
    end
  end

  // Slice adder: DPC decimal digits with carry rippling from the low digit to the high one.
  always_comb begin
    // NOTE: every variable gets a default first, so no path through this block can infer a latch.
    c         = carry_q;
    xd        = '0;
    yd        = '0;
    s         = '0;
    sum_slice = '0;
    for (int d = 0; d < DPC; d++) begin
      if (state_q == COMP) begin
        xd = 4'd9 - res_q[slice_q*SLW + 4*d +: 4];
        yd = 4'd0;
      end else begin
        xd = a_q[slice_q*SLW + 4*d +: 4];
        yd = op_q ? (4'd9 - b_q[slice_q*SLW + 4*d +: 4]) : b_q[slice_q*SLW + 4*d +: 4];
      end
      s = {1'b0, xd} + {1'b0, yd} + {4'd0, c};
      if (s > 5'd9) begin
        sum_slice[4*d +: 4] = s[3:0] + 4'd6;
        c                   = 1'b1;
      end else begin
        sum_slice[4*d +: 4] = s[3:0];
        c                   = 1'b0;
      end
    end
    sum_carry = c;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d       = state_q;
    accept        = 1'b0;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (last) state_d = (op_q && !sum_carry && !err_q) ? COMP : DONE;
      end
      COMP: begin
        if (last) state_d = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath registers: slice counter, inter-slice carry, result and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slice_q     <= '0;
      carry_q     <= 1'b0;
      res_q       <= '0;
      carry_out_q <= 1'b0;
      neg_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            slice_q <= '0;
            carry_q <= bus.op;  // the +1 of the 10's complement enters as the initial carry
            err_q   <= has_bad_digit(bus.a) | has_bad_digit(bus.b);
          end
        end
        RUN: begin
          res_q[slice_q*SLW +: SLW] <= err_q ? '0 : sum_slice;
          slice_q <= last ? '0 : slice_q + 1'b1;
          // Entering COMP needs a carry of 1 to add the +1 at slice 0.
          carry_q <= last ? 1'b1 : sum_carry;
          if (last) begin
            carry_out_q <= !op_q && !err_q && sum_carry;
            neg_q       <= op_q && !err_q && !sum_carry;
          end
        end
        COMP: begin
          res_q[slice_q*SLW +: SLW] <= sum_slice;
          slice_q <= last ? '0 : slice_q + 1'b1;
          carry_q <= sum_carry;  // the carry out of the last slice is simply dropped
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_bcd_addsub_serial.sv
// Self-checking bench: three instances (DPC = 2, 1, 14) share one stimulus stream and are
// compared against an integer reference model of decimal add / signed-magnitude subtract.
module tb_bcd_addsub_serial;
  localparam int ND   = 14;
  localparam int W    = 4 * ND;
  localparam int NDUT = 3;

  typedef struct {
    logic [W-1:0] res;
    logic         carry;
    logic         neg;
    logic         err;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         op;
  logic         out_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;

  logic         ov [NDUT];
  logic         ir [NDUT];
  logic         co [NDUT];
  logic         ng [NDUT];
  logic         er [NDUT];
  logic [W-1:0] res [NDUT];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  bcd_addsub_serial_if #(.NDIGITS(ND)) bus_p2 ();
  bcd_addsub_serial_if #(.NDIGITS(ND)) bus_p1 ();
  bcd_addsub_serial_if #(.NDIGITS(ND)) bus_p14 ();

  assign bus_p2.in_valid   = in_valid;
  assign bus_p2.op         = op;
  assign bus_p2.a          = a;
  assign bus_p2.b          = b;
  assign bus_p2.out_ready  = out_ready;
  assign bus_p1.in_valid   = in_valid;
  assign bus_p1.op         = op;
  assign bus_p1.a          = a;
  assign bus_p1.b          = b;
  assign bus_p1.out_ready  = out_ready;
  assign bus_p14.in_valid  = in_valid;
  assign bus_p14.op        = op;
  assign bus_p14.a         = a;
  assign bus_p14.b         = b;
  assign bus_p14.out_ready = out_ready;

  assign ov[0] = bus_p2.out_valid;  assign ov[1] = bus_p1.out_valid;  assign ov[2] = bus_p14.out_valid;
  assign ir[0] = bus_p2.in_ready;   assign ir[1] = bus_p1.in_ready;   assign ir[2] = bus_p14.in_ready;
  assign co[0] = bus_p2.carry_out;  assign co[1] = bus_p1.carry_out;  assign co[2] = bus_p14.carry_out;
  assign ng[0] = bus_p2.neg;        assign ng[1] = bus_p1.neg;        assign ng[2] = bus_p14.neg;
  assign er[0] = bus_p2.err;        assign er[1] = bus_p1.err;        assign er[2] = bus_p14.err;
  assign res[0] = bus_p2.result;    assign res[1] = bus_p1.result;    assign res[2] = bus_p14.result;

  bcd_addsub_serial #(.NDIGITS(ND), .DPC(2))  dut_p2  (.clk(clk), .rst(rst), .bus(bus_p2));
  bcd_addsub_serial #(.NDIGITS(ND), .DPC(1))  dut_p1  (.clk(clk), .rst(rst), .bus(bus_p1));
  bcd_addsub_serial #(.NDIGITS(ND), .DPC(14)) dut_p14 (.clk(clk), .rst(rst), .bus(bus_p14));

  function automatic int dpc_of(input int k);
    case (k)
      0:       return 2;
      1:       return 1;
      default: return 14;
    endcase
  endfunction

  function automatic int nsl_of(input int k);
    return ND / dpc_of(k);
  endfunction

  // Reference model: plain integer arithmetic on the decoded decimal values.
  function automatic longint unsigned bcd2int(input logic [W-1:0] v);
    longint unsigned acc;
    acc = 0;
    for (int d = ND - 1; d >= 0; d--) acc = acc * 10 + longint'(v[4*d +: 4]);
    return acc;
  endfunction

  function automatic logic [W-1:0] int2bcd(input longint unsigned n);
    logic [W-1:0] v;
    v = '0;
    for (int d = 0; d < ND; d++) begin
      v[4*d +: 4] = 4'(n % 10);
      n = n / 10;
    end
    return v;
  endfunction

  function automatic exp_t model(input logic opv, input logic [W-1:0] av, input logic [W-1:0] bv);
    exp_t            e;
    longint unsigned ai, bi, lim;
    e = '{res: '0, carry: 1'b0, neg: 1'b0, err: 1'b0};
    for (int d = 0; d < ND; d++) begin
      if (av[4*d +: 4] > 4'd9 || bv[4*d +: 4] > 4'd9) e.err = 1'b1;
    end
    if (e.err) return e;
    lim = 1;
    for (int d = 0; d < ND; d++) lim = lim * 10;
    ai = bcd2int(av);
    bi = bcd2int(bv);
    if (!opv) begin
      e.res   = int2bcd((ai + bi) % lim);
      e.carry = (ai + bi) >= lim;
    end else if (ai >= bi) begin
      e.res = int2bcd(ai - bi);
    end else begin
      e.res = int2bcd(bi - ai);
      e.neg = 1'b1;
    end
    return e;
  endfunction

  function automatic logic [W-1:0] rand_bcd();
    logic [W-1:0] v;
    int           nd;
    v  = '0;
    nd = $urandom_range(1, ND);
    for (int d = 0; d < nd; d++) v[4*d +: 4] = 4'($urandom_range(0, 9));
    return v;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_vals(input string name);
    for (int k = 0; k < NDUT; k++) begin
      check($sformatf("%s_ov_p%0d", name, dpc_of(k)), 64'(ov[k]), 64'd0);
      check($sformatf("%s_ir_p%0d", name, dpc_of(k)), 64'(ir[k]), 64'd1);
      check($sformatf("%s_res_p%0d", name, dpc_of(k)), 64'(res[k]), 64'd0);
      check($sformatf("%s_co_p%0d", name, dpc_of(k)), 64'(co[k]), 64'd0);
      check($sformatf("%s_neg_p%0d", name, dpc_of(k)), 64'(ng[k]), 64'd0);
      check($sformatf("%s_err_p%0d", name, dpc_of(k)), 64'(er[k]), 64'd0);
    end
  endtask

  // Issue one request to all instances, measure each latency, then check the held result.
  task automatic run_op(input string name, input logic opv, input logic [W-1:0] av, input logic [W-1:0] bv);
    exp_t e;
    int   lat [NDUT];
    bit   all_done;
    e = model(opv, av, bv);
    @(negedge clk);
    in_valid = 1'b1;
    op       = opv;
    a        = av;
    b        = bv;
    @(negedge clk);
    in_valid = 1'b0;
    op       = 1'($urandom_range(0, 1));
    a        = W'({$urandom(), $urandom()});
    b        = W'({$urandom(), $urandom()});
    for (int k = 0; k < NDUT; k++) lat[k] = ov[k] ? 0 : -1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      all_done = 1'b1;
      for (int k = 0; k < NDUT; k++) begin
        if (lat[k] < 0 && ov[k]) lat[k] = cyc;
        if (lat[k] < 0) all_done = 1'b0;
      end
      if (all_done) break;
    end
    for (int k = 0; k < NDUT; k++) begin
      check($sformatf("%s_lat_p%0d", name, dpc_of(k)), 64'(lat[k]), 64'(nsl_of(k) * (e.neg ? 2 : 1)));
      check($sformatf("%s_ov_p%0d", name, dpc_of(k)), 64'(ov[k]), 64'd1);
      check($sformatf("%s_ir_p%0d", name, dpc_of(k)), 64'(ir[k]), 64'd0);
      check($sformatf("%s_res_p%0d", name, dpc_of(k)), 64'(res[k]), 64'(e.res));
      check($sformatf("%s_co_p%0d", name, dpc_of(k)), 64'(co[k]), 64'(e.carry));
      check($sformatf("%s_neg_p%0d", name, dpc_of(k)), 64'(ng[k]), 64'(e.neg));
      check($sformatf("%s_err_p%0d", name, dpc_of(k)), 64'(er[k]), 64'(e.err));
    end
  endtask

  // Take the result: out_valid must drop and in_ready rise at the next edge.
  task automatic take(input string name);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    for (int k = 0; k < NDUT; k++) begin
      check($sformatf("%s_take_ov_p%0d", name, dpc_of(k)), 64'(ov[k]), 64'd0);
      check($sformatf("%s_take_ir_p%0d", name, dpc_of(k)), 64'(ir[k]), 64'd1);
    end
  endtask

  initial begin
    logic         opv;
    logic [W-1:0] av, bv;
    int           seen, pos;

    rst       = 1'b1;
    in_valid  = 1'b0;
    op        = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    #1;
    check_reset_vals("rst");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_vals("post_rst");

    // Decimal wrap with carry out.
    run_op("wrap", 1'b0, 56'h99999999999999, 56'h00000000000001);
    take("wrap");
    // Negative difference takes the re-complement pass.
    run_op("neg", 1'b1, 56'h5, 56'h7);
    take("neg");
    // Equal operands give zero, non-negative.
    run_op("eq", 1'b1, 56'h12345678901234, 56'h12345678901234);
    take("eq");
    // Borrow through every digit.
    run_op("borrow", 1'b1, 56'h10000000000000, 56'h1);
    take("borrow");

    // Backpressure: result held, extra request ignored while DONE.
    run_op("bp", 1'b0, 56'h47, 56'h58);
    for (int i = 0; i < 5; i++) begin
      in_valid = (i == 2);
      a        = 56'h1;
      b        = 56'h1;
      @(negedge clk);
      for (int k = 0; k < NDUT; k++) begin
        check($sformatf("bp_hold_res_p%0d", dpc_of(k)), 64'(res[k]), 64'h105);
        check($sformatf("bp_hold_ov_p%0d", dpc_of(k)), 64'(ov[k]), 64'd1);
        check($sformatf("bp_hold_ir_p%0d", dpc_of(k)), 64'(ir[k]), 64'd0);
      end
    end
    in_valid = 1'b0;
    take("bp");
    seen = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      for (int k = 0; k < NDUT; k++) if (ov[k] || !ir[k]) seen++;
    end
    check("bp_no_second_op", 64'(seen), 64'd0);

    // Reset in the third RUN cycle aborts the operation.
    @(negedge clk);
    in_valid = 1'b1;
    op       = 1'b0;
    a        = 56'h12345678901234;
    b        = 56'h11111111111111;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_reset_vals("abort");
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      for (int k = 0; k < NDUT; k++) if (ov[k]) seen++;
    end
    check("abort_no_valid", 64'(seen), 64'd0);
    run_op("after_abort", 1'b0, 56'h1, 56'h1);
    take("after_abort");

    // Illegal digits: result and flags forced to zero, timing unchanged.
    run_op("err_add", 1'b0, 56'h0000000000000A, 56'h1);
    take("err_add");
    run_op("err_sub", 1'b1, 56'h5, 56'hB7);
    take("err_sub");

    // Randomized operations against the reference model.
    for (int i = 0; i < 30; i++) begin
      opv = 1'($urandom_range(0, 1));
      av  = rand_bcd();
      bv  = ($urandom_range(0, 3) == 0) ? av : rand_bcd();
      if ($urandom_range(0, 9) == 0) begin
        pos = $urandom_range(0, ND - 1);
        bv[4*pos +: 4] = 4'($urandom_range(10, 15));
      end
      run_op($sformatf("rnd%0d", i), opv, av, bv);
      take($sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
